// File: rtl/gauss_line_ctrl.sv
// gauss_line_ctrl: turns a de/vsync RGB stream into line-buffer writes and per-line shift pulses
// Define GAUSS_LINE_PAD_EN to zero-fill short lines so every line fully rewrites the buffer.
module gauss_line_ctrl #(
   parameter int H_ACTIVE    = 640,
   parameter int V_ACTIVE    = 480,
   parameter int COL_W       = 13,
   parameter int SHIFT_DEPTH = 11
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             vsync,
   input  logic             de,
   input  logic [7:0]       r_in,
   input  logic [7:0]       g_in,
   input  logic [7:0]       b_in,
   output logic [7:0]       r,
   output logic [7:0]       g,
   output logic [7:0]       b,
   output logic [COL_W-1:0] col,
   output logic [COL_W-1:0] row,
   output logic             buff_en,
   output logic             shift_en,
   output logic             win_valid,
   output logic             frame_start,
   output logic             long_err,
   output logic             short_err
);
   localparam logic [COL_W:0]   H    = (COL_W+1)'(H_ACTIVE);
   localparam logic [COL_W:0]   W_LO = (COL_W+1)'(2);
   localparam logic [COL_W:0]   W_HI = (COL_W+1)'(H_ACTIVE - 3);
   localparam logic [COL_W:0]   ONE  = (COL_W+1)'(1);
   localparam logic [COL_W-1:0] V    = COL_W'(V_ACTIVE);
   localparam logic [COL_W-1:0] SD   = COL_W'(SHIFT_DEPTH);
   localparam logic [COL_W-1:0] INC  = COL_W'(1);

`ifdef GAUSS_LINE_PAD_EN
   typedef enum logic [2:0] {IDLE, WAIT_LINE, ACTIVE, LINE_END, PAD} state_t;
`else
   typedef enum logic [2:0] {IDLE, WAIT_LINE, ACTIVE, LINE_END} state_t;
`endif

   state_t           state, state_n;
   logic             vs_d;
   logic [COL_W:0]   cnt, cnt_n, idx;
   logic [COL_W-1:0] line_cnt, line_n, row_n;
   logic             long_n, short_n, fs_n, wr, pad, done;

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      row_n   = row;
      line_n  = line_cnt;
      long_n  = long_err;
      short_n = short_err;
      fs_n    = 1'b0;
      wr      = 1'b0;
      pad     = 1'b0;
      idx     = cnt;
      done    = 1'b0;
      if (vsync && !vs_d) begin
         // frame start wins over everything, abandoning any partial line without a shift
         state_n = WAIT_LINE;
         cnt_n   = '0;
         row_n   = '0;
         line_n  = '0;
         long_n  = 1'b0;
         short_n = 1'b0;
         fs_n    = 1'b1;
      end else begin
         case (state)
            WAIT_LINE, LINE_END: begin
               state_n = de ? ACTIVE : WAIT_LINE;
               wr      = de;
               idx     = '0;
               cnt_n   = de ? ONE : '0;
            end
            ACTIVE: begin
               if (de) begin
                  wr     = cnt < H;
                  long_n = long_err | (cnt >= H);
                  cnt_n  = &cnt ? cnt : cnt + ONE;
               end else begin
                  short_n = short_err | (cnt < H);
`ifdef GAUSS_LINE_PAD_EN
                  state_n = cnt < H ? PAD : LINE_END;
                  done    = cnt >= H;
`else
                  state_n = LINE_END;
                  done    = 1'b1;
`endif
               end
            end
`ifdef GAUSS_LINE_PAD_EN
            PAD: begin
               wr      = cnt < H;
               pad     = 1'b1;
               cnt_n   = cnt < H ? cnt + ONE : cnt;
               state_n = cnt < H ? PAD : LINE_END;
               done    = cnt >= H;
            end
`endif
            default: ;
         endcase
         if (done) begin
            row_n  = row == V ? row : row + INC;
            line_n = line_cnt == SD ? line_cnt : line_cnt + INC;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         vs_d        <= 1'b0;
         cnt         <= '0;
         line_cnt    <= '0;
         {r, g, b}   <= '0;
         col         <= '0;
         row         <= '0;
         buff_en     <= 1'b0;
         shift_en    <= 1'b0;
         win_valid   <= 1'b0;
         frame_start <= 1'b0;
         long_err    <= 1'b0;
         short_err   <= 1'b0;
      end else begin
         state       <= state_n;
         vs_d        <= vsync;
         cnt         <= cnt_n;
         line_cnt    <= line_n;
         row         <= row_n;
         long_err    <= long_n;
         short_err   <= short_n;
         frame_start <= fs_n;
         buff_en     <= wr;
         shift_en    <= done;
         col         <= wr ? idx[COL_W-1:0] : '0;
         win_valid   <= wr && line_cnt == SD && idx >= W_LO && idx <= W_HI;
         if (wr) {r, g, b} <= pad ? 24'h0 : {r_in, g_in, b_in};
      end
   end
endmodule
